// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI mode-1 master (CPOL=0, CPHA=1, LSB first) among NUM_REQ requesters.
// Define SPI_LOOPBACK_EN to capture mosi instead of miso (rx word mirrors the tx word).
module spi_txn_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      sclk,
    output logic                      cs_n,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_DONE, ST_GAP} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;

    logic                found;
    logic [PTR_W-1:0]    win;
    logic [PTR_W-1:0]    cand;
    logic [31:0]         base;
    logic [DATA_W-1:0]   tx_sel;
    logic                cap_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign cap_bit     = mosi_q;
`else
    assign cap_bit     = miso;
`endif

    // First high request scanning upward from the slot after the last winner.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        cand  = '0;
        base  = 32'(rr_ptr_q);
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((base + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        tx_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win == PTR_W'(k)) tx_sel = tx_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        rx_d      = rx_q;
        grant_d   = '0;
        done_d    = '0;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d   = ST_SETUP;
                    grant_d   = NUM_REQ'(1) << win;
                    rr_ptr_d  = win;
                    shreg_d   = tx_sel;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = tx_sel[0];
                end
            end
            ST_SETUP: begin
                if (div_cnt_q == DIV_LAST) begin
                    state_d   = ST_SHIFT;
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    mosi_d    = shreg_q[0];
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // Outputs are registered, so each half-period end decides the next sclk level.
                if (div_cnt_q != DIV_LAST) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d           = 1'b0;
                        rx_d[bit_cnt_q]  = cap_bit;
                        shreg_d          = shreg_q >> 1;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d   = ST_DONE;
                        cs_n_d    = 1'b1;
                        mosi_d    = 1'b0;
                        done_d    = NUM_REQ'(1) << rr_ptr_q;
                        rx_data_d = rx_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
                        mosi_d    = shreg_q[0];
                    end
                end
            end
            ST_DONE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= PTR_RST;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
            rx_q      <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            rx_q      <= rx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed, table-driven bench for spi_txn_arbiter with a mode-1 slave model and pin monitor.
module tb_spi_txn_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] tx_data;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [7:0]  rx_data;
    logic        busy;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;

    int n_checks = 0;
    int n_pass   = 0;

    spi_txn_arbiter #(
        .NUM_REQ(2),
        .DATA_W(8),
        .CLK_DIV(2),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .tx_data(tx_data),
        .grant(grant),
        .done(done),
        .rx_data(rx_data),
        .busy(busy),
        .sclk(sclk),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin monitor and slave model, evaluated mid-cycle away from the active edge.
    logic [7:0] slave_word = 8'h00;
    logic       miso_force = 1'b0;
    logic [7:0] mon_word   = 8'h00;
    logic [3:0] mon_bit    = 4'd0;
    int         pulses     = 0;
    int         falls      = 0;
    int         low_cnt    = 0;
    int         high_cnt   = 0;
    int         last_low   = 0;
    int         last_high  = 0;
    int         grant1_cnt = 0;
    int         done1_cnt  = 0;
    logic       cs_prev    = 1'b1;
    logic       sclk_prev  = 1'b0;

    always @(negedge clk) begin
        if (cs_n === 1'b0 && cs_prev === 1'b1) begin
            last_high = high_cnt;
            low_cnt   = 1;
            pulses    = 0;
            falls     = 0;
            mon_word  = 8'h00;
            mon_bit   = 4'd0;
        end else if (cs_n === 1'b1 && cs_prev === 1'b0) begin
            last_low = low_cnt;
            high_cnt = 1;
        end else if (cs_n === 1'b0) begin
            low_cnt++;
        end else begin
            high_cnt++;
        end
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            if (mon_bit < 4'd8) begin
                mon_word[mon_bit[2:0]] = mosi;
                miso = miso_force ? 1'b1 : slave_word[mon_bit[2:0]];
            end
            mon_bit++;
            pulses++;
        end
        if (sclk === 1'b0 && sclk_prev === 1'b1 && cs_n === 1'b0) falls++;
        if (grant[1] === 1'b1) grant1_cnt++;
        if (done[1] === 1'b1) done1_cnt++;
        cs_prev   = cs_n;
        sclk_prev = sclk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = 2'b00;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (grant !== 2'b00) begin
                g = grant;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic [1:0] d, output logic [7:0] rx);
        d  = 2'b00;
        rx = 8'h00;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (done !== 2'b00) begin
                d  = done;
                rx = rx_data;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [7:0] tx0;
        logic [7:0] tx1;
        logic [7:0] slave;
        logic [1:0] exp_g;
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [1:0] g;
        logic [1:0] d;
        logic [7:0] rx;
        int         d1_before;
        int         g1_before;
        logic [7:0] lb_exp;

        vecs[0] = '{2'b01, 8'h02, 8'h00, 8'hA5, 2'b01, 8'h02, 8'hA5};
        vecs[1] = '{2'b10, 8'h00, 8'h5A, 8'h3C, 2'b10, 8'h5A, 8'h3C};
        vecs[2] = '{2'b01, 8'hFF, 8'h00, 8'h00, 2'b01, 8'hFF, 8'h00};
        vecs[3] = '{2'b10, 8'h00, 8'h80, 8'h01, 2'b10, 8'h80, 8'h01};

        rst     = 1'b1;
        req     = 2'b11;
        tx_data = 16'h0000;
        miso    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_outputs_%0d", i),
                  32'({grant, done, rx_data, busy, sclk, cs_n, mosi}),
                  32'({2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
        end
        rst = 1'b0;
        req = 2'b00;
        tick();

        for (int i = 0; i < 4; i++) begin
            tx_data    = {vecs[i].tx1, vecs[i].tx0};
            slave_word = vecs[i].slave;
            req        = vecs[i].req;
            wait_grant(g);
            req = 2'b00;
            check($sformatf("v%0d_grant", i), 32'(g), 32'(vecs[i].exp_g));
            wait_done(d, rx);
            check($sformatf("v%0d_done", i), 32'(d), 32'(vecs[i].exp_g));
            check($sformatf("v%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d_mosi", i), 32'(mon_word), 32'(vecs[i].exp_mosi));
            check($sformatf("v%0d_cs_low", i), 32'(last_low), 32'd34);
            check($sformatf("v%0d_sclk_pulses", i), 32'(pulses), 32'd8);
        end

        // Held simultaneous requests rotate 0,1,0,1.
        tx_data    = {8'h81, 8'h10};
        slave_word = 8'h00;
        req        = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_grant(g);
            if (t == 3) req = 2'b00;
            check($sformatf("rr_grant_%0d", t), 32'(g), (t % 2 == 0) ? 32'h1 : 32'h2);
            wait_done(d, rx);
            check($sformatf("rr_mosi_%0d", t), 32'(mon_word), (t % 2 == 0) ? 32'h10 : 32'h81);
            if (t > 0) check($sformatf("rr_cs_high_%0d", t), 32'(last_high), 32'd4);
        end

        // Reset after the third falling sclk of a requester-1 transfer.
        tick();
        tx_data = {8'hC3, 8'h55};
        req     = 2'b10;
        wait_grant(g);
        req = 2'b00;
        check("abort_grant", 32'(g), 32'h2);
        d1_before = done1_cnt;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (falls >= 3) break;
        end
        check("abort_third_fall", 32'(falls), 32'd3);
        rst = 1'b1;
        tick();
        check("abort_cs_n", 32'(cs_n), 32'h1);
        check("abort_sclk", 32'(sclk), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        req = 2'b11;
        tick();
        rst = 1'b0;
        wait_grant(g);
        req = 2'b00;
        check("post_abort_grant", 32'(g), 32'h1);

        // Requester 1 pulses for one cycle while busy.
        g1_before = grant1_cnt;
        for (int k = 0; k < 5; k++) tick();
        req = 2'b10;
        tick();
        req = 2'b00;
        wait_done(d, rx);
        check("late_drop_done0", 32'(d), 32'h1);
        for (int k = 0; k < 20; k++) tick();
        check("late_drop_no_grant1", 32'(grant1_cnt), 32'(g1_before));
        check("no_done1_after_abort", 32'(done1_cnt), 32'(d1_before));

        // miso tied high: loopback build returns the tx word.
        miso_force = 1'b1;
        tx_data    = {8'h00, 8'h3C};
        req        = 2'b01;
        wait_grant(g);
        req = 2'b00;
        check("lb_grant", 32'(g), 32'h1);
        wait_done(d, rx);
`ifdef SPI_LOOPBACK_EN
        lb_exp = 8'h3C;
`else
        lb_exp = 8'hFF;
`endif
        check("lb_rx", 32'(rx), 32'(lb_exp));
        check("lb_mosi", 32'(mon_word), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI mode-1 master port (CPOL=0, CPHA=1, LSB first, active-low chip select) between NUM_REQ requesters.
- Arbitrates with round-robin priority and latches the winner's tx word.
- Sequences chip-select setup, the SCLK divider and the bit shifting, then returns the received word with a per-requester done pulse.
- Sits between the LED/control logic that produces byte streams and the external SPI pins.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DATA_W, 8, bits per transaction (>=2).
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
- GAP_CYCLES, 2, extra idle cycles with cs_n high after each transaction (>=0).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request; level, held until grant.
- tx_data  in  NUM_REQ*DATA_W  flat tx words; requester k uses bits [k*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse when the requester's word is latched.
- done  out  NUM_REQ  one-hot, one-cycle pulse when the requester's transaction completes.
- rx_data  out  DATA_W  received word; valid from the done pulse until the next done.
- busy  out  1  high in every state except IDLE.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset, when rst is sampled high: next-cycle values are grant=0, done=0, rx_data=0, busy=0, sclk=0, cs_n=1, mosi=0. State returns to IDLE and rr_ptr=NUM_REQ-1. Reset mid-transfer aborts the transaction immediately and no done pulse is issued. All outputs are registered.
- IDLE: cs_n=1, sclk=0, mosi=0.
  - If any req is high, pick the first high req scanning from rr_ptr+1 upward with wrap.
  - Next cycle: grant[w]=1, shift register <= tx_data[w], rr_ptr <= w, state SETUP.
  - A req that drops before its grant is not served.
- SETUP, CLK_DIV cycles: cs_n=0, sclk=0, mosi=shreg[0]. This gives the slave CS setup before the first edge.
- SHIFT, DATA_W bits, 2*CLK_DIV cycles per bit:
  - First half: sclk=1. The leading (rising) edge presents bit b on mosi, LSB first.
  - Second half: sclk=0. In the cycle sclk goes 0, miso is captured into the rx register at bit b. The shift register then shifts right.
  - Total cs_n low time = CLK_DIV + 2*CLK_DIV*DATA_W cycles.
- DONE, 1 cycle: cs_n=1, sclk=0, mosi=0, done[w]=1, rx_data <= rx register.
- GAP, GAP_CYCLES cycles: cs_n=1. If GAP_CYCLES=0, skip GAP and go straight to IDLE.
- Minimum cs_n high time between transactions = 2+GAP_CYCLES cycles (DONE, GAP, IDLE arbitration cycle).
- Requests arriving while busy are held and arbitrated in the next IDLE. Continuously held requests are served in strict rotation.
- Counters: the divider counter is ceil(log2(CLK_DIV)) bits (minimum 1) and the bit counter is ceil(log2(DATA_W)) bits. Both clear on entry to SETUP and on reset. There is no wrap-around beyond the terminal count.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- Defined: the rx capture takes the current mosi value instead of miso, so rx_data equals the transmitted word. The miso port stays present but is ignored.
- Undefined: the capture uses miso as specified above.
- Timing is identical in both builds.

Test Plan (bench uses NUM_REQ=2, DATA_W=8, CLK_DIV=2, GAP_CYCLES=2):
- Reset check: hold rst 3 cycles with req=2'b11 -> cs_n=1, sclk=0, mosi=0, grant=0, done=0, busy=0, rx_data=0x00 throughout.
- Single transfer: req[0]=1, tx0=0x02, slave model returns 0xA5 LSB-first on miso.
  - grant=2'b01 one cycle later; cs_n low exactly 34 cycles; 8 sclk pulses.
  - mosi at the rising edges = 0,1,0,0,0,0,0,0.
  - done=2'b01 pulse; rx_data=0xA5.
- Simultaneous requests: req=2'b11 held, tx0=0x10, tx1=0x81 -> grants in order 01,10,01,10; mosi words 0x10,0x81,0x10,0x81; cs_n high 4 cycles between each.
- Abort: assert rst after the 3rd falling sclk of a req[1] transfer.
  - Next cycle cs_n=1 and sclk=0; no done pulse.
  - After release with req=2'b11, requester 0 is granted first.
- Late drop: req[1] pulses for 1 cycle while busy -> never granted, done[1] never asserted.
- With SPI_LOOPBACK_EN: tx0=0x3C, miso tied 1 -> rx_data=0x3C. Without the macro, the same stimulus gives rx_data=0xFF.
